// File: rtl/muldiv_iter_if.sv
// Handshake bundle between the execute stage and the iterative mul/div unit.
// The master side issues operands and consumes results. The slave side is the unit.
interface muldiv_iter_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             busy;

   modport master (
      output in_valid, op, a, b, flush, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, op, a, b, flush, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/muldiv_iter.sv
// Multi-cycle RV32M multiply/divide unit.
// It uses a shift-add multiplier and a restoring divider, and retires one bit per cycle.
// Operands are reduced to magnitudes on acceptance. The sign is re-applied on the final
// iteration edge, so result only moves when the unit enters DONE.
module muldiv_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic         clk,
   input logic         rst_n,
   muldiv_iter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state, state_next;
   logic [2:0]         op_q;
   logic [2*WIDTH-1:0] acc;       // product high half : multiplier being shifted out
   logic [WIDTH-1:0]   mcand;     // multiplicand magnitude, or divisor magnitude
   logic [WIDTH-1:0]   rem;       // partial remainder; widened by one bit on each shift
   logic [WIDTH-1:0]   quo;       // dividend bits shift out as quotient bits shift in
   logic               neg_q;     // product / quotient sign (sa ^ sb)
   logic               neg_r;     // remainder sign (sa)
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   result_q;

   logic               accept, is_div, signed_a, signed_b, sa, sb;
   logic               div_zero, div_ovf, special, last;
   logic [WIDTH-1:0]   mag_a, mag_b, special_res;
   logic [WIDTH:0]     mul_sum, shifted, diff;
   logic [2*WIDTH-1:0] acc_step, prod;
   logic [WIDTH-1:0]   rem_step, quo_step, q_fix, r_fix, final_res;

   // Operand decode at the acceptance point: signedness, magnitudes and the two shortcut cases.
   always_comb begin
      accept   = bus.in_valid && (state == IDLE) && !bus.flush;
      is_div   = bus.op[2];
      signed_a = is_div ? !bus.op[0] : (bus.op[1:0] != 2'b11);
      signed_b = is_div ? !bus.op[0] : !bus.op[1];
      sa       = signed_a && bus.a[WIDTH-1];
      sb       = signed_b && bus.b[WIDTH-1];
      mag_a    = sa ? -bus.a : bus.a;
      mag_b    = sb ? -bus.b : bus.b;
      div_zero = is_div && (bus.b == '0);
      div_ovf  = is_div && !bus.op[0] && (bus.a == MOST_NEG) && (bus.b == '1);
      special  = div_zero || div_ovf;
      // NOTE: every combinational output gets a value on every path, so no latch is inferred.
      special_res = '0;
      if (div_zero)     special_res = bus.op[1] ? bus.a : '1;
      else if (div_ovf) special_res = bus.op[1] ? '0 : bus.a;
   end

   // One iteration of each algorithm, followed by sign correction and selection of the output word.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
      acc_step = {mul_sum, acc[WIDTH-1:1]};
      shifted  = {rem, quo[WIDTH-1]};
      diff     = shifted - {1'b0, mcand};
      if (!diff[WIDTH]) begin
         rem_step = diff[WIDTH-1:0];
         quo_step = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_step = shifted[WIDTH-1:0];
         quo_step = {quo[WIDTH-2:0], 1'b0};
      end
      prod  = neg_q ? -acc_step : acc_step;
      q_fix = neg_q ? -quo_step : quo_step;
      r_fix = neg_r ? -rem_step : rem_step;
      case (op_q)
         3'b000:                 final_res = prod[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         final_res = q_fix;
         default:                final_res = r_fix;
      endcase
      last = (cnt == CNT_W'(1));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers use non-blocking assignment, so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic: flush takes priority over completion and the output handshake.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = special ? DONE : CALC;
         CALC: if (bus.flush) state_next = IDLE;
               else if (last) state_next = DONE;
         DONE: if (bus.flush || bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: load on acceptance, iterate in CALC, and register the result on the final edge.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the datapath registers are ordinary flops, not a memory, so they are all reset.
      if (!rst_n) begin
         op_q     <= '0;
         acc      <= '0;
         mcand    <= '0;
         rem      <= '0;
         quo      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         cnt      <= '0;
         result_q <= '0;
      end else if (accept) begin
         op_q  <= bus.op;
         acc   <= {{WIDTH{1'b0}}, mag_b};
         mcand <= is_div ? mag_b : mag_a;
         rem   <= '0;
         quo   <= mag_a;
         neg_q <= sa ^ sb;
         neg_r <= sa;
         cnt   <= CNT_W'(WIDTH);
         if (special) result_q <= special_res;
      end else if (state == CALC && !bus.flush) begin
         cnt <= cnt - CNT_W'(1);
         if (op_q[2]) begin
            rem <= rem_step;
            quo <= quo_step;
         end else begin
            acc <= acc_step;
         end
         if (last) result_q <= final_res;
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.result    = result_q;

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised multi-cycle RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Takes over MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, so the ALU's combinational multiply and divide paths are retired.
- Uses a shift-add multiplier and a restoring divider, one bit per cycle.
- Uses valid/ready handshakes on both sides so the pipeline can stall on it; supports flush on branch/trap.

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op are presented.
- in_ready  output  1  unit can accept; high only in IDLE.
- op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  WIDTH  rs1 value.
- b  input  WIDTH  rs2 value.
- flush  input  1  abort any operation in flight.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  final result.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - result=0, counter=0, all datapath registers=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - Acceptance occurs on the edge where in_valid & in_ready.
  - On acceptance, latch op.
  - Latch magnitudes |a| and |b|, negating only for signed operands:
    - signed a for MUL/MULH/MULHSU/DIV/REM;
    - signed b for MUL/MULH/DIV/REM.
  - Latch the result sign.
  - Set counter=WIDTH and go to CALC.
- Special cases at acceptance (no CALC; go to DONE directly, out_valid high 1 edge after acceptance):
  - Divide by zero (b=0, div/rem ops): quotient = all ones; remainder = a.
  - Signed overflow (DIV/REM, a=most-negative, b=all ones): quotient = a; remainder = 0.
- CALC:
  - Each cycle decrements the counter and processes one bit.
  - MUL ops: if multiplier LSB is set, add the multiplicand into the upper half of a 2*WIDTH accumulator, then shift right by 1.
  - DIV ops: shift the remainder:dividend pair left by 1; trial-subtract the divisor; on no borrow, keep the difference and set the quotient bit.
  - When counter reaches 1, on that edge:
    - apply two's-complement sign correction (product sign, quotient sign = sa^sb, remainder sign = sa);
    - select the output: low word for MUL, high word for MULH*, quotient for DIV*, remainder for REM*;
    - register it into result and go to DONE.
- Latency for normal ops: out_valid rises WIDTH+1 edges after acceptance (33 for WIDTH=32).
- DONE:
  - out_valid=1; result held stable while out_ready=0 (backpressure for unlimited cycles).
  - The out_valid & out_ready edge returns to IDLE, clearing out_valid.
  - A new op cannot be accepted in that same cycle (in_ready=0 in DONE).
- flush:
  - In CALC or DONE, flush forces IDLE on the next edge; out_valid=0; no result is produced.
  - Flush has priority over completion and handshake.
  - In IDLE, flush blocks acceptance for that cycle.
- Width rules:
  - Accumulator is 2*WIDTH.
  - Divider remainder is WIDTH+1 so the trial subtract can detect borrow.
  - The most-negative value's magnitude is held as unsigned WIDTH bits (no overflow).
- Output stability: result changes only on the CALC->DONE or special-case->DONE edge.
- Reset mid-operation: immediate return to reset values; the in-flight result is lost.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), out_ready=1 -> out_valid at edge 33 after acceptance, result=0xFFFFFFEB.
- MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - All four: out_valid 1 edge after acceptance.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable, in_ready=0; then out_ready=1 -> IDLE on the next edge, in_ready=1.
- Flush at CALC cycle 5 -> IDLE next edge, out_valid never asserted. rst_n low at CALC cycle 12 -> all outputs at reset values immediately. A following DIVU 9/3 completes with result 3.
